frl_multiport: RTL and testbench

Multi-port free register list for the renaming stage. It supplies up to `RD_PORTS` free physical register tags per cycle to dispatch and takes back up to `WR_PORTS` freed tags per cycle from ROB commit. On a branch flush it restores the head pointer from the CFC checkpoint. It generalises the single-port free list with parametrised depth and tag width, all-or-nothing multi-allocation, compacted multi-commit pushes, an occupancy count and an overflow error flag.

---
 rtl/rename_pkg.sv | 29 ++
 rtl/frl_compact.sv | 40 ++++
 rtl/frl_multiport.sv | 193 +++++++++++++++++++
 tb/tb_frl_multiport.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rename_pkg
//  Description : Shared constants, tag/pointer typedefs and a constant-time
//                ceil(log2) helper for the renaming-stage free register list.
//  Revision    : 1.0  initial release
// ============================================================================
package rename_pkg;

  // Ceil(log2(value)); usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int PHYS_W     = 6;   // physical register tag width
  localparam int DEPTH      = 32;  // free-list entries (power of two)
  localparam int FIRST_FREE = 32;  // tag held by entry 0 after reset
  localparam int PTR_W      = clog2(DEPTH) + 1;

  typedef logic [PHYS_W-1:0] phys_tag_t;
  typedef logic [PTR_W-1:0]  frl_ptr_t;

endpackage
`default_nettype wire

// File: rtl/frl_compact.sv
`default_nettype none
// ============================================================================
//  Module      : frl_compact
//  Description : Combinational lane compactor. Valid lanes are packed in
//                ascending lane order into the low slots of packed_tag; the
//                number of valid lanes is returned in packed_cnt. Unused
//                slots read as zero.
//  Ports       : lane_vld   [LANES]        per-lane valid
//                lane_tag   [LANES*TAG_W]  per-lane tag, lane i at slice i
//                packed_tag [LANES*TAG_W]  compacted tags, slot k at slice k
//                packed_cnt [CNT_W]        number of valid lanes
//  Revision    : 1.0  initial release
// ============================================================================
module frl_compact
  import rename_pkg::*;
#(
  parameter int LANES = 2,
  parameter int TAG_W = 6,
  parameter int CNT_W = clog2(LANES + 1)
) (
  input  logic [LANES-1:0]       lane_vld,
  input  logic [LANES*TAG_W-1:0] lane_tag,
  output logic [LANES*TAG_W-1:0] packed_tag,
  output logic [CNT_W-1:0]       packed_cnt
);

  // packed_cnt doubles as the write cursor while scanning lanes low to high.
  always_comb begin
    packed_tag = '0;
    packed_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_vld[i]) begin
        packed_tag[int'(packed_cnt)*TAG_W +: TAG_W] = lane_tag[i*TAG_W +: TAG_W];
        packed_cnt = packed_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frl_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : frl_multiport
//  Description : Multi-port free register list. Hands out up to RD_PORTS
//                free physical tags per cycle (all-or-nothing), accepts up
//                to WR_PORTS freed tags per cycle (compacted), restores the
//                head pointer from the CFC checkpoint on flush, and raises a
//                sticky overflow flag if a push would exceed DEPTH.
//  Config      : FRL_BYPASS_EN - when defined, tags freed this cycle are
//                forwarded to the read slots and counted as available in the
//                same cycle.
//  Ports       : clk, resetb (sync, active low)
//                Dis_FrlReadCnt       tags requested this cycle
//                Frl_Grant            request granted
//                Frl_RdPhyAddr        slot j = tag at head+j
//                Frl_AvailCnt         tags allocatable this cycle
//                Frl_Empty            Frl_AvailCnt == 0
//                Rob_Commit           per-lane commit valid
//                Rob_CommitRegWrite   per-lane destination-write flag
//                Rob_CommitPrePhyAddr per-lane freed tag
//                Cdb_Flush            restore head from Cfc_FrlHeadPtr
//                Cfc_FrlHeadPtr       checkpointed head pointer
//                Frl_HeadPtr          current head pointer
//                Frl_Overflow         sticky overflow error
//  Revision    : 1.0  initial release
// ============================================================================
module frl_multiport
  import rename_pkg::*;
#(
  parameter int PHYS_W     = rename_pkg::PHYS_W,
  parameter int DEPTH      = rename_pkg::DEPTH,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int FIRST_FREE = rename_pkg::FIRST_FREE,
  localparam int PTR_W     = clog2(DEPTH) + 1,
  localparam int RC_W      = clog2(RD_PORTS) + 1
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic [RC_W-1:0]              Dis_FrlReadCnt,
  output logic                         Frl_Grant,
  output logic [RD_PORTS*PHYS_W-1:0]   Frl_RdPhyAddr,
  output logic [PTR_W-1:0]             Frl_AvailCnt,
  output logic                         Frl_Empty,
  input  logic [WR_PORTS-1:0]          Rob_Commit,
  input  logic [WR_PORTS-1:0]          Rob_CommitRegWrite,
  input  logic [WR_PORTS*PHYS_W-1:0]   Rob_CommitPrePhyAddr,
  input  logic                         Cdb_Flush,
  input  logic [PTR_W-1:0]             Cfc_FrlHeadPtr,
  output logic [PTR_W-1:0]             Frl_HeadPtr,
  output logic                         Frl_Overflow
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int WC_W  = clog2(WR_PORTS + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PHYS_W-1:0] mem_q [DEPTH];
  logic [PHYS_W-1:0] mem_d [DEPTH];
  logic              overflow_q, overflow_d;

  // --------------------------------------------------------------------------
  // Commit lane compaction
  // --------------------------------------------------------------------------
  logic [WR_PORTS-1:0]        lane_vld;
  logic [WR_PORTS*PHYS_W-1:0] push_tag;
  logic [WC_W-1:0]            push_cnt;

  assign lane_vld = Rob_Commit & Rob_CommitRegWrite;

  frl_compact #(
    .LANES (WR_PORTS),
    .TAG_W (PHYS_W),
    .CNT_W (WC_W)
  ) u_compact (
    .lane_vld   (lane_vld),
    .lane_tag   (Rob_CommitPrePhyAddr),
    .packed_tag (push_tag),
    .packed_cnt (push_cnt)
  );

  // --------------------------------------------------------------------------
  // Occupancy, availability and grant
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] push_ext;
  logic [PTR_W:0]   count_plus_push;
  logic             overflow_hit;

  // Pointer difference wraps naturally; the wrap bit disambiguates full/empty.
  assign count           = tail_q - head_q;
  assign push_ext        = PTR_W'(push_cnt);
  assign count_plus_push = {1'b0, count} + {1'b0, push_ext};
  assign overflow_hit    = count_plus_push > (PTR_W+1)'(DEPTH);

`ifdef FRL_BYPASS_EN
  assign Frl_AvailCnt = overflow_hit ? PTR_W'(DEPTH) : count_plus_push[PTR_W-1:0];
`else
  assign Frl_AvailCnt = count;
`endif

  assign Frl_Empty = (Frl_AvailCnt == '0);

  // A zero-size request is never reported as granted.
  assign Frl_Grant = (Dis_FrlReadCnt != '0) &&
                     (PTR_W'(Dis_FrlReadCnt) <= Frl_AvailCnt) &&
                     !Cdb_Flush;

  assign Frl_HeadPtr  = head_q;
  assign Frl_Overflow = overflow_q;

  // --------------------------------------------------------------------------
  // Read slots
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] rd_idx;
`ifdef FRL_BYPASS_EN
  logic [PTR_W-1:0] byp_off;
`endif

  always_comb begin
    rd_idx        = '0;
    Frl_RdPhyAddr = '0;
`ifdef FRL_BYPASS_EN
    byp_off       = '0;
`endif
    for (int j = 0; j < RD_PORTS; j++) begin
      rd_idx = head_q[IDX_W-1:0] + IDX_W'(j);
      Frl_RdPhyAddr[j*PHYS_W +: PHYS_W] = mem_q[rd_idx];
`ifdef FRL_BYPASS_EN
      // Slots at or beyond the tail come from this cycle's compacted pushes.
      byp_off = PTR_W'(j) - count;
      if ((PTR_W'(j) >= count) && (byp_off < PTR_W'(WR_PORTS))) begin
        Frl_RdPhyAddr[j*PHYS_W +: PHYS_W] = push_tag[int'(byp_off)*PHYS_W +: PHYS_W];
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] wr_idx;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    wr_idx     = '0;

    // Flush overrides any grant (the grant is already masked by the flush).
    if (Cdb_Flush) begin
      head_d = Cfc_FrlHeadPtr;
    end else if (Frl_Grant) begin
      head_d = head_q + PTR_W'(Dis_FrlReadCnt);
    end

    // Pushes are all-or-nothing: an overflowing cycle writes nothing.
    if (overflow_hit) begin
      overflow_d = 1'b1;
    end else begin
      for (int k = 0; k < WR_PORTS; k++) begin
        if (PTR_W'(k) < push_ext) begin
          wr_idx        = tail_q[IDX_W-1:0] + IDX_W'(k);
          mem_d[wr_idx] = push_tag[k*PHYS_W +: PHYS_W];
        end
      end
      tail_d = tail_q + push_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      head_q     <= '0;
      tail_q     <= PTR_W'(DEPTH);
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PHYS_W'(FIRST_FREE + i);
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frl_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frl_multiport
//  Description : Self-checking bench for frl_multiport: a directed vector
//                table from reset, hand-written drain/commit/overflow/reset
//                sequences, and a FIFO-model wrap-around run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frl_multiport;
  import rename_pkg::*;

`ifdef FRL_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        resetb;
  logic [1:0]  rc;
  logic        grant;
  logic [11:0] rd_addr;
  logic [5:0]  avail;
  logic        empty;
  logic [1:0]  cm;
  logic [1:0]  rw;
  logic [11:0] ctag;
  logic        flush;
  logic [5:0]  cfc;
  logic [5:0]  headp;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  frl_multiport dut (
    .clk                  (clk),
    .resetb               (resetb),
    .Dis_FrlReadCnt       (rc),
    .Frl_Grant            (grant),
    .Frl_RdPhyAddr        (rd_addr),
    .Frl_AvailCnt         (avail),
    .Frl_Empty            (empty),
    .Rob_Commit           (cm),
    .Rob_CommitRegWrite   (rw),
    .Rob_CommitPrePhyAddr (ctag),
    .Cdb_Flush            (flush),
    .Cfc_FrlHeadPtr       (cfc),
    .Frl_HeadPtr          (headp),
    .Frl_Overflow         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    rc = 2'd0; cm = 2'b00; rw = 2'b00; ctag = '0; flush = 1'b0; cfc = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    resetb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  typedef struct {
    logic [1:0] rc;
    logic [1:0] cm;
    logic [1:0] rw;
    logic [5:0] t0;
    logic [5:0] t1;
    logic       fl;
    logic [5:0] cfc;
    logic       eg;
    logic [5:0] es0;
    logic [5:0] es1;
    int         eav;
    logic [5:0] ehd;
  } vec_t;

  vec_t tbl[7];

  int fl_q[$];
  int out_q[$];
  int pushed[$];
  int vis[$];
  logic [5:0] head_m;

  initial begin
    resetb = 1'b0;
    idle();

    //              rc    cm     rw     t0  t1  fl cfc eg  s0  s1  avail        head
    tbl[0] = '{2'd2, 2'b00, 2'b00, 0,  0,  0, 0, 1, 32, 33, 32,          0};
    tbl[1] = '{2'd0, 2'b00, 2'b00, 0,  0,  0, 0, 0, 34, 35, 30,          2};
    tbl[2] = '{2'd1, 2'b00, 2'b00, 0,  0,  0, 0, 1, 34, 35, 30,          2};
    tbl[3] = '{2'd2, 2'b11, 2'b11, 5,  9,  0, 0, 1, 35, 36, 29 + 2*BYP,  3};
    tbl[4] = '{2'd0, 2'b11, 2'b10, 7,  10, 0, 0, 0, 37, 38, 29 + BYP,    5};
    tbl[5] = '{2'd2, 2'b01, 2'b01, 11, 0,  1, 4, 0, 37, 38, 30 + BYP,    5};
    tbl[6] = '{2'd0, 2'b00, 2'b00, 0,  0,  0, 0, 0, 36, 37, 32,          4};

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("reset_head", int'(headp), 0);
    chk("reset_avail", int'(avail), 32);
    chk("reset_empty", int'(empty), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_grant_rc0", int'(grant), 0);
    chk("reset_slot0", int'(rd_addr[5:0]), 32);
    chk("reset_slot1", int'(rd_addr[11:6]), 33);

    // ---------------- vector table ----------------
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      rc = tbl[v].rc; cm = tbl[v].cm; rw = tbl[v].rw;
      ctag = {tbl[v].t1, tbl[v].t0}; flush = tbl[v].fl; cfc = tbl[v].cfc;
      #1;
      chk($sformatf("tbl%0d_grant", v), int'(grant), int'(tbl[v].eg));
      chk($sformatf("tbl%0d_slot0", v), int'(rd_addr[5:0]), int'(tbl[v].es0));
      chk($sformatf("tbl%0d_slot1", v), int'(rd_addr[11:6]), int'(tbl[v].es1));
      chk($sformatf("tbl%0d_avail", v), int'(avail), tbl[v].eav);
      chk($sformatf("tbl%0d_head", v), int'(headp), int'(tbl[v].ehd));
    end

    // ---------------- drain to empty + compacted commit ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      rc = 2'd2;
      #1;
      chk($sformatf("drain%0d_grant", i), int'(grant), 1);
    end
    @(negedge clk);
    idle();
    #1;
    chk("drained_empty", int'(empty), 1);
    chk("drained_avail", int'(avail), 0);
    rc = 2'd1;
    #1;
    chk("empty_req1_grant", int'(grant), 0);
    @(negedge clk);
    idle();
    #1;
    chk("empty_head_held", int'(headp), 32);
    // lane 0 has RegWrite low: only tag 9 is pushed
    cm = 2'b11; rw = 2'b10; ctag = {6'd9, 6'd5};
    #1;
`ifdef FRL_BYPASS_EN
    chk("commit_byp_avail", int'(avail), 1);
    chk("commit_byp_slot0", int'(rd_addr[5:0]), 9);
`else
    chk("commit_nobyp_empty", int'(empty), 1);
`endif
    @(negedge clk);
    idle();
    rc = 2'd2;
    #1;
    chk("after_commit_slot0", int'(rd_addr[5:0]), 9);
    chk("after_commit_avail", int'(avail), 1);
    chk("avail1_req2_grant", int'(grant), 0);
    @(negedge clk);
    idle();
    #1;
    chk("avail1_head_held", int'(headp), 32);
    rc = 2'd1;
    #1;
    chk("avail1_req1_grant", int'(grant), 1);
    @(negedge clk);
    idle();
    #1;
    chk("post_alloc_head", int'(headp), 33);
    chk("post_alloc_empty", int'(empty), 1);

    // ---------------- overflow ----------------
    do_reset();
    @(negedge clk);
    cm = 2'b01; rw = 2'b01; ctag = {6'd0, 6'd7};
    #1;
    chk("ovf_before", int'(ovf), 0);
    @(negedge clk);
    idle();
    #1;
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_avail", int'(avail), 32);
    chk("ovf_slot0_unwritten", int'(rd_addr[5:0]), 32);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      rc = 2'd2;
      #1;
      chk($sformatf("ovf_alloc%0d_grant", i), int'(grant), 1);
    end
    @(negedge clk);
    idle();
    #1;
    chk("ovf_sticky", int'(ovf), 1);
    chk("ovf_head", int'(headp), 6);

    // ---------------- reset mid-flush/commit wins ----------------
    @(negedge clk);
    resetb = 1'b0; rc = 2'd2; cm = 2'b11; rw = 2'b11; ctag = {6'd3, 6'd4};
    flush = 1'b1; cfc = 6'd9;
    @(negedge clk);
    resetb = 1'b1;
    idle();
    #1;
    chk("rst_mid_head", int'(headp), 0);
    chk("rst_mid_avail", int'(avail), 32);
    chk("rst_mid_slot0", int'(rd_addr[5:0]), 32);
    chk("rst_mid_ovf", int'(ovf), 0);

    // ---------------- wrap-around with FIFO model ----------------
    do_reset();
    fl_q.delete();
    out_q.delete();
    for (int i = 0; i < 32; i++) fl_q.push_back(32 + i);
    head_m = 6'd0;
    for (int cyc = 0; cyc < 160; cyc++) begin
      int r;
      bit eg;
      @(negedge clk);
      idle();
      r  = $urandom_range(0, 3);
      rc = (r >= 2) ? 2'd2 : 2'(r);
      pushed.delete();
      for (int l = 0; l < 2; l++) begin
        cm[l] = ($urandom_range(0, 3) != 0);
        rw[l] = ($urandom_range(0, 3) != 0);
        ctag[l*6 +: 6] = 6'($urandom_range(0, 63));
        if (cm[l] && rw[l]) begin
          if (out_q.size() > 0) begin
            ctag[l*6 +: 6] = 6'(out_q.pop_front());
            pushed.push_back(int'(ctag[l*6 +: 6]));
          end else begin
            rw[l] = 1'b0;
          end
        end
      end
      vis = fl_q;
      if (BYP == 1) begin
        foreach (pushed[p]) vis.push_back(pushed[p]);
      end
      eg = (rc != 2'd0) && (int'(rc) <= vis.size());
      #1;
      chk($sformatf("wrap%0d_avail", cyc), int'(avail), vis.size());
      chk($sformatf("wrap%0d_grant", cyc), int'(grant), int'(eg));
      chk($sformatf("wrap%0d_head", cyc), int'(headp), int'(head_m));
      if (vis.size() > 0) chk($sformatf("wrap%0d_slot0", cyc), int'(rd_addr[5:0]), vis[0]);
      if (vis.size() > 1) chk($sformatf("wrap%0d_slot1", cyc), int'(rd_addr[11:6]), vis[1]);
      @(posedge clk);
      foreach (pushed[p]) fl_q.push_back(pushed[p]);
      if (eg) begin
        for (int k = 0; k < int'(rc); k++) out_q.push_back(fl_q.pop_front());
        head_m = head_m + 6'(rc);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk("wrap_final_head", int'(headp), int'(head_m));
    chk("wrap_final_avail", int'(avail), fl_q.size());
    chk("wrap_no_ovf", int'(ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
